// File: rtl/fp_addsub_if.sv
// fp_addsub_if -- request/result bundle for the fp_addsub block.
//   start  : operation request, level-held by the requester until done
//   op     : 0 = a+b, 1 = a-b
//   a, b   : operands, {sign, exponent[EXP_W], fraction[MAN_W]}
//   sum    : registered result
//   done   : result valid
//   busy   : operation in flight
//   flags  : {invalid, overflow, underflow, inexact}, valid with done
// master = requester side, slave = fp_addsub side.
interface fp_addsub_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
   logic         done;
   logic         busy;
   logic [3:0]   flags;

   modport master (output start, op, a, b, input sum, done, busy, flags);
   modport slave  (input start, op, a, b, output sum, done, busy, flags);
endinterface

// File: rtl/fp_addsub.sv
// fp_addsub -- multi-cycle floating-point adder/subtractor, round-to-nearest-even.
// Subnormal inputs are flushed to zero; results that fall below the normal
// range flush to signed zero with underflow.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous, active-low
//   bus    : fp_addsub_if slave (start, op, a, b -> sum, done, busy, flags)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; captures a, b, op
// UNPACK | decode fields, resolve NaN/inf/zero, order operands by magnitude
// ALIGN  | shift smaller significand right into G/R/S
// ADD    | add or subtract magnitudes
// NORM   | carry shift right or leading-zero shift left
// ROUND  | round-to-nearest-even, range check, write sum/flags
// DONE   | result presented; back to IDLE once done is shown and start drops
module fp_addsub #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic       clk,
   input  logic       reset,
   fp_addsub_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int DW  = MAN_W + 5;          // carry, hidden, fraction, G, R, S
   localparam int XW  = EXP_W + 2;          // signed exponent with headroom
   localparam int LZW = $clog2(DW);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;

   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

   state_t               state;
   logic [W-1:0]         a_q, b_q;
   logic                 op_q;
   logic                 sign_big, eff_sub, zero_res;
   logic signed [XW-1:0] exp_r;
   logic [EXP_W-1:0]     exp_diff;
   logic [MAN_W:0]       sig_big, sig_small;
   logic [DW-2:0]        small_al;
   logic [DW-1:0]        mag;
   logic [W-1:0]         sum_q;
   logic [3:0]           flags_q;
   logic                 done_q, busy_q;

   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] frac_a, frac_b;
   logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_ge_b;

   always_comb begin
      sign_a = a_q[W-1];
      sign_b = b_q[W-1] ^ op_q;
      exp_a  = a_q[W-2:MAN_W];
      exp_b  = b_q[W-2:MAN_W];
      frac_a = a_q[MAN_W-1:0];
      frac_b = b_q[MAN_W-1:0];
      nan_a  = (exp_a == '1) && (frac_a != '0);
      nan_b  = (exp_b == '1) && (frac_b != '0);
      inf_a  = (exp_a == '1) && (frac_a == '0);
      inf_b  = (exp_b == '1) && (frac_b == '0);
      zero_a = (exp_a == '0);
      zero_b = (exp_b == '0);
      // exponent-then-fraction order equals magnitude order for normal numbers
      a_ge_b = a_q[W-2:0] >= b_q[W-2:0];
   end

   logic [DW-2:0] ext_small, low_mask, shifted;

   always_comb begin
      ext_small = {sig_small, 3'b000};
      low_mask  = ~({(DW-1){1'b1}} << exp_diff);
      if ({{(32-EXP_W){1'b0}}, exp_diff} > 32'(MAN_W + 3))
         shifted = {{(DW-2){1'b0}}, 1'b1};
      else
         shifted = (ext_small >> exp_diff)
                 | {{(DW-2){1'b0}}, |(ext_small & low_mask)};
   end

   // leading zeros of mag below the carry bit; highest set bit wins
   logic [LZW-1:0] lz;

   always_comb begin
      lz = LZW'(DW - 1);
      for (int i = 0; i < DW - 1; i++)
         if (mag[i]) lz = LZW'(DW - 2 - i);
   end

   logic                 rnd_g, rnd_r, rnd_s, rnd_inc;
   logic [MAN_W+1:0]     rnd_sig;
   logic [MAN_W-1:0]     frac_f;
   logic signed [XW-1:0] exp_f;

   always_comb begin
      rnd_g   = mag[2];
      rnd_r   = mag[1];
      rnd_s   = mag[0];
      rnd_inc = rnd_g & (rnd_r | rnd_s | mag[3]);
      rnd_sig = {1'b0, mag[DW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
      // rounding carry: significand became 10.000..., renormalize
      exp_f   = rnd_sig[MAN_W+1] ? exp_r + EXP_ONE : exp_r;
      frac_f  = rnd_sig[MAN_W+1] ? {MAN_W{1'b0}} : rnd_sig[MAN_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         sign_big  <= 1'b0;
         eff_sub   <= 1'b0;
         zero_res  <= 1'b0;
         exp_r     <= '0;
         exp_diff  <= '0;
         sig_big   <= '0;
         sig_small <= '0;
         small_al  <= '0;
         mag       <= '0;
         sum_q     <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  op_q   <= bus.op;
                  state  <= UNPACK;
                  busy_q <= 1'b1;
               end
            end
            UNPACK: begin
               state   <= DONE;
               busy_q  <= 1'b0;
               flags_q <= 4'b0000;
               if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
                  sum_q   <= QNAN;
                  flags_q <= 4'b1000;
               end else if (inf_a) begin
                  sum_q <= {sign_a, a_q[W-2:0]};
               end else if (inf_b) begin
                  sum_q <= {sign_b, b_q[W-2:0]};
               end else if (zero_a && zero_b) begin
                  sum_q <= {sign_a & sign_b, {(W-1){1'b0}}};
               end else if (zero_a) begin
                  sum_q <= {sign_b, b_q[W-2:0]};
               end else if (zero_b) begin
                  sum_q <= a_q;
               end else begin
                  state    <= ALIGN;
                  busy_q   <= 1'b1;
                  eff_sub  <= sign_a ^ sign_b;
                  zero_res <= 1'b0;
                  if (a_ge_b) begin
                     sign_big  <= sign_a;
                     exp_r     <= $signed({2'b00, exp_a});
                     exp_diff  <= exp_a - exp_b;
                     sig_big   <= {1'b1, frac_a};
                     sig_small <= {1'b1, frac_b};
                  end else begin
                     sign_big  <= sign_b;
                     exp_r     <= $signed({2'b00, exp_b});
                     exp_diff  <= exp_b - exp_a;
                     sig_big   <= {1'b1, frac_b};
                     sig_small <= {1'b1, frac_a};
                  end
               end
            end
            ALIGN: begin
               small_al <= shifted;
               state    <= ADD;
            end
            ADD: begin
               if (eff_sub)
                  mag <= {1'b0, sig_big, 3'b000} - {1'b0, small_al};
               else
                  mag <= {1'b0, sig_big, 3'b000} + {1'b0, small_al};
               state <= NORM;
            end
            NORM: begin
               if (mag == '0) begin
                  zero_res <= 1'b1;
               end else if (mag[DW-1]) begin
                  mag   <= {1'b0, mag[DW-1:2], mag[1] | mag[0]};
                  exp_r <= exp_r + EXP_ONE;
               end else begin
                  mag   <= mag << lz;
                  exp_r <= exp_r - $signed({{(XW-LZW){1'b0}}, lz});
               end
               state <= ROUND;
            end
            ROUND: begin
               state  <= DONE;
               busy_q <= 1'b0;
               if (zero_res) begin
                  sum_q   <= '0;
                  flags_q <= 4'b0000;
               end else if (exp_f >= EXP_MAX) begin
                  sum_q   <= {sign_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flags_q <= 4'b0101;
               end else if (exp_f <= EXP_ZERO) begin
                  sum_q   <= {sign_big, {(W-1){1'b0}}};
                  flags_q <= 4'b0011;
               end else begin
                  sum_q   <= {sign_big, exp_f[EXP_W-1:0], frac_f};
                  flags_q <= {3'b000, rnd_g | rnd_r | rnd_s};
               end
            end
            DONE: begin
               // done shows for at least one cycle before start may release it
               if (done_q && !bus.start) begin
                  done_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sum   = sum_q;
   assign bus.flags = flags_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_fp_addsub.sv
// tb_fp_addsub -- directed vectors plus randomized operands against an
// exact-arithmetic reference model (wide integer add, then RNE rounding).
module tb_fp_addsub;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fp_addsub_if #(.EXP_W(8), .MAN_W(23)) bus ();

   fp_addsub #(.EXP_W(8), .MAN_W(23)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: operands become exact integers on a common scale, are added
   // exactly, and the result is rounded once to 24 significant bits.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic op, output logic [31:0] s,
                                     output logic [3:0] f, output int lat);
      logic         sa, sb, sr, inexact;
      int           ea, eb, emin, p, k, e_res;
      logic [299:0] va, vb, m, rem, half, keep;
      bit           nan_a, nan_b, inf_a, inf_b, za, zb;
      sa = a[31];
      sb = b[31] ^ op;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      nan_a = (ea == 255) && (a[22:0] != 0);
      nan_b = (eb == 255) && (b[22:0] != 0);
      inf_a = (ea == 255) && (a[22:0] == 0);
      inf_b = (eb == 255) && (b[22:0] == 0);
      za = (ea == 0);
      zb = (eb == 0);
      s = '0;
      f = '0;
      lat = 2;
      if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
         s = 32'h7FC0_0000;
         f = 4'b1000;
      end else if (inf_a) s = {sa, a[30:0]};
      else if (inf_b) s = {sb, b[30:0]};
      else if (za && zb) s = {sa & sb, 31'b0};
      else if (za) s = {sb, b[30:0]};
      else if (zb) s = a;
      else begin
         lat  = 6;
         emin = (ea < eb) ? ea : eb;
         va   = 300'({1'b1, a[22:0]}) << (ea - emin);
         vb   = 300'({1'b1, b[22:0]}) << (eb - emin);
         if (sa == sb) begin m = va + vb; sr = sa; end
         else if (va >= vb) begin m = va - vb; sr = sa; end
         else begin m = vb - va; sr = sb; end
         if (m != 0) begin
            p = 0;
            for (int i = 0; i < 300; i++) if (m[i]) p = i;
            inexact = 1'b0;
            if (p > 23) begin
               k    = p - 23;
               keep = m >> k;
               rem  = m & ((300'd1 << k) - 300'd1);
               half = 300'd1 << (k - 1);
               inexact = (rem != 0);
               if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
            end else begin
               keep = m << (23 - p);
            end
            e_res = emin + p - 23;
            if (keep[24]) begin keep = keep >> 1; e_res++; end
            if (e_res >= 255) begin s = {sr, 8'hFF, 23'h0}; f = 4'b0101; end
            else if (e_res <= 0) begin s = {sr, 31'b0}; f = 4'b0011; end
            else begin s = {sr, 8'(e_res), keep[22:0]}; f = {3'b000, inexact}; end
         end
      end
   endfunction

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] s_exp, input logic [3:0] f_exp,
                         input int lat_exp, input bit deep);
      int n;
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      bus.op = op;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (deep) check_eq({name, "_busy"}, 32'(bus.busy), 32'd1);
      // operands must already be captured; scramble the bus
      bus.a = $urandom;
      bus.b = $urandom;
      bus.op = ~op;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.done && n < 20);
      check_eq({name, "_latency"}, 32'(n), 32'(lat_exp));
      check_eq({name, "_sum"}, bus.sum, s_exp);
      check_eq({name, "_flags"}, 32'(bus.flags), 32'(f_exp));
      if (deep) begin
         repeat (3) @(posedge clk);
         #1;
         check_eq({name, "_hold_done"}, 32'(bus.done), 32'd1);
         check_eq({name, "_hold_sum"}, bus.sum, s_exp);
      end
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check_eq({name, "_done_drop"}, 32'(bus.done), 32'd0);
      if (deep) begin
         check_eq({name, "_kept_sum"}, bus.sum, s_exp);
         check_eq({name, "_kept_flags"}, 32'(bus.flags), 32'(f_exp));
         check_eq({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
      end
   endtask

   function automatic logic [31:0] rand_operand(input int near_exp);
      logic [31:0] v;
      int sel, e;
      v = $urandom;
      sel = $urandom_range(0, 19);
      if (sel == 0) v[30:23] = 8'hFF;
      else if (sel == 1) begin v[30:23] = 8'hFF; v[22:0] = '0; end
      else if (sel == 2) v[30:23] = 8'h00;
      else begin
         if (sel < 13) e = near_exp + $urandom_range(0, 8) - 4;
         else if (sel < 16) e = near_exp + $urandom_range(0, 60) - 30;
         else e = $urandom_range(1, 254);
         if (e < 1) e = 1;
         if (e > 254) e = 254;
         v[30:23] = 8'(e);
      end
      return v;
   endfunction

   initial begin
      logic [31:0] ra, rb, rs;
      logic [3:0]  rf;
      logic        rop;
      int          rl;

      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.a = '0;
      bus.b = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      check_eq("rst_sum", bus.sum, 32'h0);
      check_eq("rst_flags", 32'(bus.flags), 32'h0);
      check_eq("rst_done", 32'(bus.done), 32'h0);
      check_eq("rst_busy", 32'(bus.busy), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      run_op("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 6, 1);
      run_op("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000, 6, 1);
      run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 4'b1000, 2, 1);
      run_op("max_overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101, 6, 0);
      run_op("tie_even_down", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001, 6, 0);
      run_op("tie_even_up", 32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 4'b0001, 6, 0);
      run_op("underflow", 32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 4'b0011, 6, 0);
      run_op("neg_zeros", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000, 2, 0);
      run_op("zero_sub_zero", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b0000, 2, 0);
      run_op("subnorm_a", 32'h0000_0001, 32'h4000_0000, 1'b1, 32'hC000_0000, 4'b0000, 2, 0);
      run_op("b_zero", 32'hC049_0FDB, 32'h8000_0000, 1'b0, 32'hC049_0FDB, 4'b0000, 2, 0);
      run_op("nan_in", 32'h7FC1_2345, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000, 2, 0);
      run_op("fin_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 4'b0000, 2, 0);

      // reset while the operation sits in ALIGN
      @(negedge clk);
      bus.a = 32'h3F80_0000;
      bus.b = 32'h4000_0000;
      bus.op = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      bus.start = 1'b0;
      #1;
      check_eq("midrst_sum", bus.sum, 32'h0);
      check_eq("midrst_flags", 32'(bus.flags), 32'h0);
      check_eq("midrst_done", 32'(bus.done), 32'h0);
      check_eq("midrst_busy", 32'(bus.busy), 32'h0);
      @(posedge clk);
      #1;
      check_eq("midrst_still_idle", 32'(bus.busy), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      run_op("after_reset", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 6, 0);

      for (int i = 0; i < 300; i++) begin
         ra  = rand_operand($urandom_range(1, 254));
         rb  = rand_operand(int'(ra[30:23]));
         rop = 1'($urandom_range(0, 1));
         ref_model(ra, rb, rop, rs, rf, rl);
         run_op("rand", ra, rb, rop, rs, rf, rl, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  operation request, level-held by the requester.
REQ-006 The block SHALL have port op  input  1  0 = a+b, 1 = a-b.
REQ-007 The block SHALL have ports a, b  input  W  IEEE-754-style operands.
REQ-008 The block SHALL have port sum  output  W  registered result.
REQ-009 The block SHALL have port done  output  1  result valid.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-011 The block SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, registered, valid with done.

Function
REQ-012 FSM states SHALL be IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a, b, op and go to UNPACK; otherwise stay.
REQ-014 start, a, b, op SHALL be ignored in every state except IDLE and DONE; captured operands SHALL be held until DONE.
REQ-015 Effective b sign SHALL be b[W-1] XOR op.
REQ-016 UNPACK special cases SHALL go straight to DONE, at the 2nd edge after capture, in this priority:
  - either operand NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1.
  - inf and inf of opposite effective sign -> canonical qNaN, invalid=1.
  - one operand inf -> that inf with its effective sign.
  - a zero -> b with effective sign, except both zero -> sign = sign_a AND sign_beff.
  - b zero -> a unchanged.
REQ-017 Exponent field 0 with nonzero fraction (subnormal) SHALL be treated as zero.
REQ-018 Non-special operations SHALL assert done exactly 6 edges after the capturing edge.
REQ-019 ALIGN: the smaller-exponent significand (hidden 1 prepended) SHALL be right-shifted by the exponent difference into guard, round and sticky bits; shifted-out ones SHALL OR into sticky.
REQ-020 Differences greater than MAN_W+3 SHALL reduce the smaller operand to sticky only.
REQ-021 ADD: the datapath SHALL be MAN_W+5 bits wide (carry, hidden, fraction, G, R, S) and SHALL add or subtract magnitudes per effective signs.
REQ-022 On equal exponents the larger magnitude SHALL be the minuend, so the magnitude is never negative.
REQ-023 NORM: carry-out SHALL shift right 1 (LSB ORed into sticky) and increment the exponent.
REQ-024 NORM: otherwise a single-cycle leading-zero count SHALL left-shift to restore the hidden 1 and decrement the exponent accordingly.
REQ-025 An exact-zero difference SHALL yield +0 with flags 0.
REQ-026 ROUND SHALL be round-to-nearest-even: increment when G AND (R OR S OR LSB).
REQ-027 A rounding carry SHALL renormalize: exponent +1, fraction 0.
REQ-028 inexact SHALL be set when G, R or S is nonzero, or on overflow or underflow.
REQ-029 A final exponent of all ones or more SHALL give signed infinity with overflow=1 and inexact=1.
REQ-030 A final exponent of 0 or less SHALL give signed zero with underflow=1 and inexact=1.
REQ-031 DONE: done=1 and sum/flags SHALL hold while start=1.
REQ-032 start=0 in DONE SHALL return to IDLE with done=0 at that edge; sum and flags SHALL hold their last value.

Reset
REQ-033 reset=0 SHALL immediately, regardless of clk or state (including mid-operation), force IDLE, sum=0, flags=0, done=0, busy=0, and discard captured operands.
REQ-034 After reset release, the first start SHALL be sampled no earlier than the next rising edge.

Verification (EXP_W=8, MAN_W=23)
REQ-035 0x3F800000 + 0x40000000, op=0 -> sum 0x40400000, flags 0, done 6 edges after capture.
REQ-036 0x3F800000 - 0x3F800000, op=1 -> sum 0x00000000, flags 0.
REQ-037 0x7F800000 + 0xFF800000 -> sum 0x7FC00000, flags 4'b1000, done 2 edges after capture.
REQ-038 0x7F7FFFFF + 0x7F7FFFFF -> sum 0x7F800000, flags 4'b0101.
REQ-039 Ties-to-even: 0x3F800000 + 0x33800000 -> 0x3F800000 with inexact; 0x3F800001 + 0x33800000 -> 0x3F800002 with inexact.
REQ-040 reset low during ALIGN -> outputs 0 and IDLE at once; a following 1.0+2.0 request -> 0x40400000.
